// File: rtl/game_logic_if.sv
// Signal bundle between the tube generator/bird source and the game-state controller.
interface game_logic_if;
  logic             start;
  logic [10:0]      bird_y;
  logic [2:0][10:0] tube_x;
  logic [2:0][10:0] gap_y;
  logic             game_rst;
  logic             playing;
  logic             game_over;
  logic             collision;
  logic [15:0]      score_bcd;
  logic [15:0]      best_bcd;

  modport master (
    output start, bird_y, tube_x, gap_y,
    input  game_rst, playing, game_over, collision, score_bcd, best_bcd
  );

  modport slave (
    input  start, bird_y, tube_x, gap_y,
    output game_rst, playing, game_over, collision, score_bcd, best_bcd
  );
endinterface

// File: rtl/game_logic.sv
// Game-state controller: tube/ground collision detection, BCD scoring with best score,
// and the IDLE/PLAY/DEAD sequencer that drives the tube generator's game_rst.
module game_logic #(
  parameter int SCREEN_WIDTH  = 1024,
  parameter int SCREEN_HEIGHT = 768,
  parameter int TUBE_WIDTH    = 120,
  parameter int GAP_HEIGHT    = 250,
  parameter int BIRD_X        = 200,
  parameter int BIRD_SIZE     = 40,
  parameter int DEAD_HOLD     = 65_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  game_logic_if.slave  bus
);

  localparam logic signed [11:0] BIRD_L     = 12'(BIRD_X);
  localparam logic signed [11:0] BIRD_R     = 12'(BIRD_X + BIRD_SIZE);
  localparam logic signed [11:0] SCR_W      = 12'(SCREEN_WIDTH);
  localparam logic signed [11:0] TUBE_W     = 12'(TUBE_WIDTH);
  localparam logic        [11:0] BIRD_SZ    = 12'(BIRD_SIZE);
  localparam logic        [11:0] GAP_H      = 12'(GAP_HEIGHT);
  localparam logic        [11:0] GROUND_ROW = 12'(SCREEN_HEIGHT);
  localparam logic        [10:0] BIRD_COL   = 11'(BIRD_X);
  localparam int                 HOLD_W     = $clog2(DEAD_HOLD + 1);
  localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(DEAD_HOLD - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

  state_t              state;
  logic                start_d;
  logic                start_rise;
  logic signed [11:0]  right [3];
  logic signed [11:0]  left  [3];
  logic [11:0]         bird_bot;
  logic [2:0]          hit;
  logic [2:0]          pass;
  logic                ground;
  logic [2:0]          hit_q;
  logic [2:0]          pass_q;
  logic                ground_q;
  logic [2:0]          scored;
  logic                any_hit;
  logic [1:0]          npass;
  logic [15:0]         score;
  logic [15:0]         score_next;
  logic [15:0]         best;
  logic [HOLD_W-1:0]   hold;
  logic                game_rst_q;
  logic                playing_q;
  logic                game_over_q;
  logic                collision_q;

  // Digit-serial BCD add of a small increment; a carry out of the top digit saturates.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] v, input logic [1:0] n);
    logic [15:0] r;
    logic [4:0]  inc;
    logic [4:0]  d;
    r   = v;
    inc = 5'(n);
    for (int k = 0; k < 4; k++) begin
      d = {1'b0, v[4*k +: 4]} + inc;
      if (d > 5'd9) begin
        r[4*k +: 4] = 4'(d - 5'd10);
        inc         = 5'd1;
      end else begin
        r[4*k +: 4] = d[3:0];
        inc         = 5'd0;
      end
    end
    return (inc != 5'd0) ? 16'h9999 : r;
  endfunction

  assign start_rise = bus.start & ~start_d;

  // Left edges go negative near the screen edge, hence the signed 12-bit compare.
  always_comb begin
    bird_bot = {1'b0, bus.bird_y} + BIRD_SZ;
    ground   = (bird_bot >= GROUND_ROW);
    hit      = '0;
    pass     = '0;
    for (int i = 0; i < 3; i++) begin
      right[i] = signed'({1'b0, bus.tube_x[i]});
      left[i]  = right[i] - TUBE_W;
      hit[i]   = (BIRD_L < right[i]) && (BIRD_R > left[i]) && (left[i] < SCR_W) &&
                 (({1'b0, bus.bird_y} < {1'b0, bus.gap_y[i]}) ||
                  (bird_bot > ({1'b0, bus.gap_y[i]} + GAP_H)));
      pass[i]  = (bus.tube_x[i] < BIRD_COL) && !scored[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d  <= 1'b0;
      hit_q    <= '0;
      pass_q   <= '0;
      ground_q <= 1'b0;
      scored   <= '0;
    end else begin
      start_d  <= bus.start;
      hit_q    <= hit;
      pass_q   <= pass;
      ground_q <= ground;
      for (int i = 0; i < 3; i++) begin
        if (state == IDLE || bus.tube_x[i] >= BIRD_COL)
          scored[i] <= 1'b0;
        else if (pass[i])
          scored[i] <= 1'b1;
      end
    end
  end

  assign any_hit    = (|hit_q) | ground_q;
  assign npass      = {1'b0, pass_q[0]} + {1'b0, pass_q[1]} + {1'b0, pass_q[2]};
  assign score_next = bcd_add_sat(score, npass);

  // The final pass of a game is counted before DEAD, so best compares against score_next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      game_rst_q  <= 1'b1;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      collision_q <= 1'b0;
      score       <= '0;
      best        <= '0;
      hold        <= '0;
    end else begin
      collision_q <= 1'b0;
      case (state)
        IDLE: begin
          score <= '0;
          if (start_rise) begin
            state      <= PLAY;
            game_rst_q <= 1'b0;
            playing_q  <= 1'b1;
          end
        end
        PLAY: begin
          score <= score_next;
          if (any_hit) begin
            state       <= DEAD;
            playing_q   <= 1'b0;
            game_over_q <= 1'b1;
            collision_q <= 1'b1;
            hold        <= HOLD_INIT;
            if (score_next > best)
              best <= score_next;
          end
        end
        DEAD: begin
          if (hold != '0)
            hold <= hold - 1'b1;
          else if (start_rise) begin
            state       <= IDLE;
            game_over_q <= 1'b0;
            game_rst_q  <= 1'b1;
            score       <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          game_rst_q  <= 1'b1;
          playing_q   <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.game_rst  = game_rst_q;
  assign bus.playing   = playing_q;
  assign bus.game_over = game_over_q;
  assign bus.collision = collision_q;
  assign bus.score_bcd = score;
  assign bus.best_bcd  = best;

endmodule

// File: tb/tb_game_logic.sv
// Bench for game_logic: a reference model pushes expected score/collision/game_over per
// driven sample, and a negedge monitor pops them when the DUT's two-cycle pipeline delivers.
module tb_game_logic;
  localparam int DEAD_HOLD = 8;

  typedef struct {
    int          due;
    logic [15:0] score;
    logic        coll;
    logic        over;
  } sb_item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  sb_item_t sb_q[$];
  sb_item_t chk_it;
  int       m_score;
  int       m_best;
  bit       m_play;
  bit       m_scored [3];
  bit       hold_seq [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_logic_if bus ();

  game_logic #(
    .SCREEN_WIDTH (1024),
    .SCREEN_HEIGHT(768),
    .TUBE_WIDTH   (120),
    .GAP_HEIGHT   (250),
    .BIRD_X       (200),
    .BIRD_SIZE    (40),
    .DEAD_HOLD    (DEAD_HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      chk_it = sb_q.pop_front();
      checkOutput("sb_score", bus.score_bcd, chk_it.score);
      checkOutput("sb_collision", 16'(bus.collision), 16'(chk_it.coll));
      checkOutput("sb_game_over", 16'(bus.game_over), 16'(chk_it.over));
    end
  end

  // Drive one sample and predict what the DUT shows two edges after it is sampled.
  task automatic applyStimulus(input int t0, input int t1, input int t2, input int by, input int gy);
    int       tx [3];
    int       np;
    bit       hit;
    sb_item_t it;
    tx[0] = t0;
    tx[1] = t1;
    tx[2] = t2;
    @(negedge clk);
    bus.bird_y = 11'(by);
    for (int i = 0; i < 3; i++) begin
      bus.tube_x[i] = 11'(tx[i]);
      bus.gap_y[i]  = 11'(gy);
    end
    np  = 0;
    hit = (by + 40 >= 768);
    for (int i = 0; i < 3; i++) begin
      if (tx[i] < 200 && !m_scored[i]) np++;
      m_scored[i] = (tx[i] < 200);
      if ((200 < tx[i]) && (240 > tx[i] - 120) && ((by < gy) || (by + 40 > gy + 250))) hit = 1'b1;
    end
    it.coll = 1'b0;
    if (m_play) begin
      m_score = (m_score + np > 9999) ? 9999 : m_score + np;
      if (hit) begin
        m_play  = 1'b0;
        it.coll = 1'b1;
        if (m_score > m_best) m_best = m_score;
      end
    end
    it.due   = cyc + 2;
    it.score = toBcd(m_score);
    it.over  = !m_play;
    sb_q.push_back(it);
  endtask

  task automatic doPasses(input int n);
    int left = n;
    while (left >= 3) begin
      applyStimulus(199, 199, 199, 300, 250);
      applyStimulus(300, 300, 300, 300, 250);
      left -= 3;
    end
    while (left > 0) begin
      applyStimulus(199, 300, 300, 300, 250);
      applyStimulus(300, 300, 300, 300, 250);
      left--;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("drain", 16'(sb_q.size()), 16'd0);
  endtask

  task automatic startGame();
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bird_y = 11'd300;
    for (int i = 0; i < 3; i++) begin
      bus.tube_x[i] = 11'd300;
      bus.gap_y[i]  = 11'd250;
    end
    @(negedge clk);
    checkOutput("idle_game_rst", 16'(bus.game_rst), 16'd1);
    checkOutput("idle_score", bus.score_bcd, 16'h0000);
    bus.start = 1'b1;
    @(negedge clk);
    checkOutput("start_game_rst", 16'(bus.game_rst), 16'd0);
    checkOutput("start_playing", 16'(bus.playing), 16'd1);
    checkOutput("start_score", bus.score_bcd, 16'h0000);
    bus.start = 1'b0;
    m_play    = 1'b1;
    m_score   = 0;
    for (int i = 0; i < 3; i++) m_scored[i] = 1'b0;
  endtask

  task automatic returnToIdle();
    bus.start = 1'b0;
    repeat (DEAD_HOLD + 2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("back_idle", 16'(bus.game_rst), 16'd1);
    checkOutput("back_idle_over", 16'(bus.game_over), 16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: run exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hold_seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    m_score  = 0;
    m_best   = 0;
    m_play   = 1'b0;
    bus.start  = 1'b0;
    bus.bird_y = 11'd300;
    for (int i = 0; i < 3; i++) begin
      bus.tube_x[i] = 11'd300;
      bus.gap_y[i]  = 11'd250;
      m_scored[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_game_rst", 16'(bus.game_rst), 16'd1);
    checkOutput("rst_playing", 16'(bus.playing), 16'd0);
    checkOutput("rst_game_over", 16'(bus.game_over), 16'd0);
    checkOutput("rst_collision", 16'(bus.collision), 16'd0);
    checkOutput("rst_score", bus.score_bcd, 16'h0000);
    checkOutput("rst_best", bus.best_bcd, 16'h0000);
    rst_n = 1'b1;

    // Game 1: sweep a tube past the bird inside the gap, then die above the gap.
    startGame();
    for (int tx = 400; tx >= 200; tx -= 25) applyStimulus(tx, 1100, 1100, 300, 250);
    repeat (4) applyStimulus(199, 1100, 1100, 300, 250);
    drain();
    checkOutput("sweep_score", bus.score_bcd, 16'h0001);
    applyStimulus(260, 1100, 1100, 100, 250);
    drain();
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 1) checkOutput("coll_low", 16'(bus.collision), 16'd0);
      if (j == 4) begin
        checkOutput("score_frozen", bus.score_bcd, toBcd(m_score));
        checkOutput("best_game1", bus.best_bcd, 16'h0001);
        checkOutput("dead_not_playing", 16'(bus.playing), 16'd0);
      end
      if (j == 8) checkOutput("hold_early_start", 16'(bus.game_over), 16'd1);
      if (j == 9) begin
        checkOutput("hold_idle", 16'(bus.game_rst), 16'd1);
        checkOutput("hold_over_low", 16'(bus.game_over), 16'd0);
      end
      if (j <= 8) bus.start = hold_seq[j-1];
    end
    bus.start = 1'b0;

    // Game 2: BCD digit carry, then a pure ground collision.
    startGame();
    doPasses(9);
    drain();
    checkOutput("bcd_0009", bus.score_bcd, 16'h0009);
    doPasses(1);
    drain();
    checkOutput("bcd_0010", bus.score_bcd, 16'h0010);
    doPasses(2);
    applyStimulus(1100, 1100, 1100, 728, 250);
    drain();
    checkOutput("ground_over", 16'(bus.game_over), 16'd1);
    returnToIdle();
    checkOutput("best_game2", bus.best_bcd, 16'h0012);

    // Game 3: lower score, last pass lands in the same sample as the hit.
    startGame();
    doPasses(4);
    applyStimulus(199, 260, 1100, 100, 250);
    drain();
    checkOutput("pass_and_hit", bus.score_bcd, 16'h0005);
    returnToIdle();
    checkOutput("best_keeps_max", bus.best_bcd, 16'h0012);

    // Game 4: hundreds/thousands carry and saturation, then asynchronous reset mid-play.
    startGame();
    doPasses(999);
    drain();
    checkOutput("bcd_0999", bus.score_bcd, 16'h0999);
    doPasses(1);
    drain();
    checkOutput("bcd_1000", bus.score_bcd, 16'h1000);
    doPasses(8999);
    drain();
    checkOutput("bcd_9999", bus.score_bcd, 16'h9999);
    doPasses(1);
    drain();
    checkOutput("bcd_saturate", bus.score_bcd, 16'h9999);
    checkOutput("best_during_play", bus.best_bcd, 16'h0012);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_game_rst", 16'(bus.game_rst), 16'd1);
    checkOutput("async_playing", 16'(bus.playing), 16'd0);
    checkOutput("async_game_over", 16'(bus.game_over), 16'd0);
    checkOutput("async_collision", 16'(bus.collision), 16'd0);
    checkOutput("async_score", bus.score_bcd, 16'h0000);
    checkOutput("async_best", bus.best_bcd, 16'h0000);
    sb_q.delete();
    m_best = 0;
    m_play = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    startGame();
    doPasses(1);
    drain();
    checkOutput("post_reset_score", bus.score_bcd, 16'h0001);
    checkOutput("post_reset_best", bus.best_bcd, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
